// File: rtl/stat_display.sv
// Multiplexed 8-digit hex display of the selected run-statistics counter.
// Optional leading-zero blanking is enabled by defining STAT_DISPLAY_BLANK_EN.
module stat_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] total_cycles_i,
  input  logic [31:0] uncondi_num_i,
  input  logic [31:0] condi_num_i,
  input  logic [31:0] condi_suc_num_i,
  input  logic [31:0] syscall_out_i,
  input  logic        halt_i,
  input  logic        next_i,
  output logic [2:0]  mode_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       dig_q, dig_d;
  logic [2:0]       mode_q, mode_d;
  logic             next_q;
  logic [31:0]      shown_q, shown_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick, frame_end, step, blank;
  logic [31:0]      src;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (dig_q == 3'd7);
  assign step      = next_i && !next_q;

  always_comb begin
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    dig_d  = tick ? dig_q + 3'd1 : dig_q;
    mode_d = mode_q;
    if (step) mode_d = (mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1;
  end

  // Source follows the post-step mode so a step coinciding with frame_end loads the new source.
  always_comb begin
    case (mode_d)
      3'd1:    src = total_cycles_i;
      3'd2:    src = uncondi_num_i;
      3'd3:    src = condi_num_i;
      3'd4:    src = condi_suc_num_i;
      default: src = syscall_out_i;
    endcase
    shown_d = (step || frame_end) ? src : shown_q;
  end

`ifdef STAT_DISPLAY_BLANK_EN
  logic [7:0] lead_zero;
  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lead_zero
      assign lead_zero[gi] = (shown_q[31:4*gi] == '0);
    end
  endgenerate
  assign blank = lead_zero[dig_q];
`else
  assign blank = 1'b0;
`endif

  assign nibble = shown_q[{dig_q, 2'b00} +: 4];

  always_comb begin
    an_d  = ~(8'b1 << dig_q);
    seg_d = hex7(nibble);
    dp_d  = !((dig_q == 3'd0) && halt_i);
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      dig_q   <= '0;
      mode_q  <= '0;
      next_q  <= 1'b0;
      shown_q <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      dig_q   <= dig_d;
      mode_q  <= mode_d;
      next_q  <= next_i;
      shown_q <= shown_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign mode_o = mode_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = dp_q;

endmodule
